// File: rtl/count_capture_pkg.sv
// Shared constants and helpers for the count_capture block.
package count_capture_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Pointer width (without the wrap bit) needed to index a FIFO of the given depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead register FIFO.
// Pointers carry an extra wrap bit, so full and empty can be told apart.
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter int data_w = 2 * DEF_WIDTH,
    parameter int depth  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [data_w-1:0] din,
    output logic [data_w-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int aw = ptr_w(depth);

    logic [aw:0]       wr_ptr_reg;
    logic [aw:0]       rd_ptr_reg;
    logic [data_w-1:0] mem_reg [depth];
    logic              pop_ok;
    logic              push_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[aw] != rd_ptr_reg[aw]) &&
                   (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside a pop.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head entry is presented combinationally (show-ahead).
    assign dout = mem_reg[rd_ptr_reg[aw-1:0]];

    // Each storage slot loads din when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg[aw-1:0] == aw'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Advance the write and read pointers on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/count_capture.sv
// Timestamp capture: on each rising edge of trig, store cnt and the modular
// delta from the previous accepted capture, and hand the pairs out over valid/ready.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] cnt,
    input  logic             trig,
    output logic [width-1:0] out_stamp,
    output logic [width-1:0] out_delta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf
);

    typedef struct packed {
        logic [width-1:0] stamp;
        logic [width-1:0] delta;
    } entry_t;

    logic             trig_d_reg;
    logic [width-1:0] last_stamp_reg;
    logic             overflow_reg;
    logic             rise;
    logic             pop;
    logic             accept;
    logic             drop;
    logic             full;
    logic             empty;
    entry_t           new_entry;
    entry_t           head_entry;

    // trig_d resets high so that trig held through reset is not seen as an edge.
    assign rise = trig & ~trig_d_reg;
    assign pop  = out_valid & out_ready;

    assign accept = rise & (~full | pop);
    assign drop   = rise & ~accept;

    assign new_entry.stamp = cnt;
    assign new_entry.delta = cnt - last_stamp_reg;

    assign out_valid = ~empty;
    assign out_stamp = head_entry.stamp;
    assign out_delta = head_entry.delta;
    assign overflow  = overflow_reg;

    capture_fifo #(
        .data_w (2 * width),
        .depth  (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (new_entry),
        .dout  (head_entry),
        .full  (full),
        .empty (empty)
    );

    // Edge-detect delay register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trig_d_reg <= 1'b1;
        else     trig_d_reg <= trig;
    end

    // Reference for the next delta; only accepted captures move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_stamp_reg <= '0;
        else if (accept) last_stamp_reg <= cnt;
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overflow_reg <= 1'b0;
        else if (drop)    overflow_reg <= 1'b1;
        else if (clr_ovf) overflow_reg <= 1'b0;
    end

endmodule

// File: doc/count_capture.md
# count_capture

Timestamp-capture stage directly downstream of the free-running `Counter`. On each rising edge of `trig` it samples `cnt` together with the modular delta from the previous accepted capture. It buffers these pairs in a small FIFO and delivers them to a consumer over a valid/ready handshake. Used for event timing and period measurement against the shared count base.

## Interface
- `width`, 8, bit width of `cnt`, `out_stamp` and `out_delta`; must match the upstream `Counter`.
- `depth`, 4, FIFO entries; power of two, ≥ 2.

- `clk`  in  1  clock shared with `Counter`.
- `rst`  in  1  reset, asynchronous, active-high.
- `cnt`  in  width  count value from `Counter`.
- `trig`  in  1  event input, synchronous to `clk`.
- `out_stamp`  out  width  `cnt` value captured for the head entry.
- `out_delta`  out  width  head entry stamp minus previous accepted stamp, mod 2^width.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts head this cycle.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Edge detect: `trig_d` register, reset value 1. `rise = trig & ~trig_d`. A `trig` held high through reset does not produce a capture.
- Capture on `rise`: `stamp = cnt`, `delta = cnt - last_stamp` truncated to width bits (wrap-around natural).
- `last_stamp` resets to 0. The first capture after reset therefore has `delta = stamp`.
- Accept condition: `rise & (~full | (out_valid & out_ready))`. A pop frees the slot in the same cycle.
- Accepted capture: push {stamp, delta} and update `last_stamp`.
- Dropped capture: no push, `last_stamp` unchanged, `overflow` set.
- Pop: `out_valid & out_ready` advances the head.
- FIFO is show-ahead: `out_stamp`/`out_delta` are valid whenever `out_valid=1`. Outputs are undefined-but-stable (hold last) when `out_valid=0`.
- `overflow`: set on a drop, cleared by `clr_ovf`. If both happen in the same cycle, set wins.
- Handshake: once `out_valid` rises, the head data is held stable until popped.

## Timing
- Reset (async, immediate): `out_valid=0`, `overflow=0`, `out_stamp=0`, `out_delta=0`, FIFO empty, `last_stamp=0`, `trig_d=1`.
- Latency:
  - `rise` sampled at edge t is pushed at edge t.
  - `out_valid=1` from edge t onward if the FIFO was empty (one cycle `trig`-to-valid).
- `cnt` is sampled at the same edge where `rise` is seen.
- Throughput: one capture and one pop per cycle, sustained.
- Empty plus simultaneous push: no same-cycle bypass. `out_valid` rises on the next cycle.
- Full plus push plus pop in the same cycle: both occur, level unchanged, no overflow.
- Reset asserted mid-operation: all buffered entries are discarded and no partial pop occurs.

## Structure
- Package `count_capture_pkg`: default constants (`DEF_WIDTH=8`, `DEF_DEPTH=4`) and a `ptr_w(depth)` function returning clog2(depth).
- The parameter-dependent entry type stays local to the module.
- Sub-module `capture_fifo`:
  - Parameterised by data width (2·width) and `depth`.
  - Register array, read/write pointers with an extra wrap bit for full/empty.
  - Show-ahead read port, push/pop/full/empty ports, same async reset.
- Top level holds the edge detect, delta subtractor, `last_stamp` and `overflow` logic.

## Test plan
- Hold `trig=1` through reset, release `rst`, keep `trig=1` for 5 cycles -> no capture, `out_valid=0`, all outputs 0.
- `out_ready=1`, rises at `cnt=5` then `cnt=12` -> entries (5,5) then (12,7). `out_valid` high one cycle each, starting one cycle after each rise.
- Wrap case: rises at `cnt=250` then `cnt=4` -> second entry delta 10.
- `out_ready=0`, rises at cnt 10, 20, 30, 40, 50:
  - 4 entries stored, 5th dropped, `overflow=1`.
  - Draining yields deltas 10, 10, 10, 10; the next rise at 60 gives delta 20.
- FIFO full with pop and rise in the same cycle -> capture accepted and `overflow` stays 0. Then assert `clr_ovf` in the same cycle as a drop -> `overflow` remains 1.
- With 3 entries buffered, assert `rst` between clock edges -> `out_valid` and `overflow` go to 0 immediately. After release, the first capture's delta equals its stamp.
